// File: rtl/npu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : npu_pkg                                                      |
// | Purpose : Shared definitions for the LD execution stage: default       |
// |           sizing, micro-instruction field layout, source-select codes  |
// |           and the stage state encoding.                                |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package npu_pkg;

  // Default sizing of the LD path.
  localparam int LD_NVRF  = 2;
  localparam int LD_VRFAW = 9;
  localparam int LD_DW    = 512;
  localparam int LD_CNTW  = 32;

  // Single-bit flags, as offsets above the flag base of the uinst.
  localparam int FLAG_SRC    = 0;
  localparam int FLAG_LAST   = 1;
  localparam int FLAG_INTR   = 2;
  localparam int FLAG_REPORT = 3;

  // Source-select codes.
  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_MFU  = 1'b1;

  // Field offsets (LSB first: vrf_id, vrf0_addr, vrf1_addr, flags).
  // Functions so a parameterised top can derive its own layout.
  function automatic int ld_off_vrf0a(input int nvrf);
    return 2 * nvrf;
  endfunction

  function automatic int ld_off_vrf1a(input int nvrf, input int vrfaw);
    return 2 * nvrf + vrfaw;
  endfunction

  function automatic int ld_off_flags(input int nvrf, input int vrfaw);
    return 2 * nvrf + 2 * vrfaw;
  endfunction

  // Micro-instruction layout at default sizing.
  typedef struct packed {
    logic                    report;
    logic                    intr;
    logic                    last;
    logic                    src_sel;
    logic [LD_VRFAW-1:0]     vrf1_addr;
    logic [LD_VRFAW-1:0]     vrf0_addr;
    logic [2*LD_NVRF-1:0]    vrf_id;
  } ld_uinst_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/ld_exec_hout.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ld_exec_hout                                                 |
// | Purpose : One-entry valid/ready holding register for the host output. |
// |           A load in the same cycle as a drain replaces the content    |
// |           and keeps the entry valid.                                   |
// | Ports   : clk, rst        clock, async active-high reset              |
// |           i_load, i_data  capture i_data into the entry               |
// |           i_rdy           consumer accepts the current entry          |
// |           o_valid, o_data entry content                               |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ld_exec_hout #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_rdy,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (i_rdy) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ld_exec.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ld_exec                                                      |
// | Purpose : LD execution stage. Pops one micro-instruction and one data |
// |           vector (host or MFU FIFO) per fire, writes the vector to    |
// |           the selected VRFs one cycle later and optionally forwards   |
// |           it to the host output. Emits done/interrupt pulses.         |
// | Ports   : o_ld_uinst_rd_en/i_ld_uinst_rd_rdy/_dout  uinst FIFO        |
// |           o_host_rd_en/i_host_rd_rdy/_dout          host vector FIFO  |
// |           o_mfu_rd_en/i_mfu_rd_rdy/_dout            MFU vector FIFO   |
// |           o_vrf_wr_en, o_vrf0/1_wr_addr, o_vrf_wr_data VRF write port |
// |           o_host_wr_en/i_host_wr_rdy/o_host_wr_data host output       |
// |           o_inst_done, o_interrupt, o_vec_count, o_busy  status       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ld_exec
  import npu_pkg::*;
#(
  parameter int NVRF   = LD_NVRF,
  parameter int VRFAW  = LD_VRFAW,
  parameter int DW     = LD_DW,
  parameter int UIW_LD = 2*NVRF + 2*VRFAW + 4,
  parameter int CNTW   = LD_CNTW
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_ld_uinst_rd_en,
  input  logic              i_ld_uinst_rd_rdy,
  input  logic [UIW_LD-1:0] i_ld_uinst_rd_dout,
  output logic              o_host_rd_en,
  input  logic              i_host_rd_rdy,
  input  logic [DW-1:0]     i_host_rd_dout,
  output logic              o_mfu_rd_en,
  input  logic              i_mfu_rd_rdy,
  input  logic [DW-1:0]     i_mfu_rd_dout,
  output logic [2*NVRF-1:0] o_vrf_wr_en,
  output logic [VRFAW-1:0]  o_vrf0_wr_addr,
  output logic [VRFAW-1:0]  o_vrf1_wr_addr,
  output logic [DW-1:0]     o_vrf_wr_data,
  output logic              o_host_wr_en,
  input  logic              i_host_wr_rdy,
  output logic [DW-1:0]     o_host_wr_data,
  output logic              o_inst_done,
  output logic              o_interrupt,
  output logic [CNTW-1:0]   o_vec_count,
  output logic              o_busy
);

  localparam int OFF_VRF0A = ld_off_vrf0a(NVRF);
  localparam int OFF_VRF1A = ld_off_vrf1a(NVRF, VRFAW);
  localparam int OFF_FLAGS = ld_off_flags(NVRF, VRFAW);

  // Decoded micro-instruction fields.
  logic [2*NVRF-1:0] w_vrf_id;
  logic [VRFAW-1:0]  w_vrf0_addr;
  logic [VRFAW-1:0]  w_vrf1_addr;
  logic              w_src_sel;
  logic              w_last;
  logic              w_intr;
  logic              w_report;

  assign w_vrf_id    = i_ld_uinst_rd_dout[0 +: 2*NVRF];
  assign w_vrf0_addr = i_ld_uinst_rd_dout[OFF_VRF0A +: VRFAW];
  assign w_vrf1_addr = i_ld_uinst_rd_dout[OFF_VRF1A +: VRFAW];
  assign w_src_sel   = i_ld_uinst_rd_dout[OFF_FLAGS + FLAG_SRC];
  assign w_last      = i_ld_uinst_rd_dout[OFF_FLAGS + FLAG_LAST];
  assign w_intr      = i_ld_uinst_rd_dout[OFF_FLAGS + FLAG_INTR];
  assign w_report    = i_ld_uinst_rd_dout[OFF_FLAGS + FLAG_REPORT];

  logic          w_src_rdy;
  logic [DW-1:0] w_src_data;
  logic          w_hout_valid;
  logic          w_fire;

  assign w_src_rdy  = (w_src_sel == SRC_MFU) ? i_mfu_rd_rdy  : i_host_rd_rdy;
  assign w_src_data = (w_src_sel == SRC_MFU) ? i_mfu_rd_dout : i_host_rd_dout;

  // A reporting uinst needs the holding register free or draining this
  // cycle; non-reporting uinsts are never held back by the host output.
  assign w_fire = i_ld_uinst_rd_rdy & w_src_rdy &
                  (~w_report | ~w_hout_valid | i_host_wr_rdy);

  assign o_ld_uinst_rd_en = w_fire;
  assign o_host_rd_en     = w_fire & (w_src_sel == SRC_HOST);
  assign o_mfu_rd_en      = w_fire & (w_src_sel == SRC_MFU);

  // Write stage and status registers.
  logic [2*NVRF-1:0] r_vrf_wr_en;
  logic [VRFAW-1:0]  r_vrf0_wr_addr;
  logic [VRFAW-1:0]  r_vrf1_wr_addr;
  logic [DW-1:0]     r_vrf_wr_data;
  logic              r_inst_done;
  logic              r_interrupt;
  logic [CNTW-1:0]   r_vec_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vrf_wr_en    <= '0;
      r_vrf0_wr_addr <= '0;
      r_vrf1_wr_addr <= '0;
      r_vrf_wr_data  <= '0;
      r_inst_done    <= 1'b0;
      r_interrupt    <= 1'b0;
      r_vec_count    <= '0;
    end else begin
      r_vrf_wr_en <= w_fire ? w_vrf_id : '0;
      r_inst_done <= w_fire & w_last;
      r_interrupt <= w_fire & w_last & w_intr;
      if (w_fire) begin
        r_vrf0_wr_addr <= w_vrf0_addr;
        r_vrf1_wr_addr <= w_vrf1_addr;
        r_vrf_wr_data  <= w_src_data;
        r_vec_count    <= r_vec_count + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_vrf_wr_en    = r_vrf_wr_en;
  assign o_vrf0_wr_addr = r_vrf0_wr_addr;
  assign o_vrf1_wr_addr = r_vrf1_wr_addr;
  assign o_vrf_wr_data  = r_vrf_wr_data;
  assign o_inst_done    = r_inst_done;
  assign o_interrupt    = r_interrupt;
  assign o_vec_count    = r_vec_count;

  ld_exec_hout #(
    .DW(DW)
  ) u_hout (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_fire & w_report),
    .i_data  (w_src_data),
    .i_rdy   (i_host_wr_rdy),
    .o_valid (w_hout_valid),
    .o_data  (o_host_wr_data)
  );

  assign o_host_wr_en = w_hout_valid;

  // State reflects what the register stages will hold after this edge:
  // a fire fills the write stage; otherwise an undrained host entry stalls.
  ld_state_t r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      if (w_fire) begin
        r_state <= ST_ACTIVE;
      end else if (w_hout_valid & ~i_host_wr_rdy) begin
        r_state <= ST_STALL;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/ld_exec.md
# ld_exec

Execution stage directly downstream of the LD micro-instruction scheduler. It pops one LD micro-instruction per vector and pops one data vector from the selected source: host input FIFO or MFU result FIFO. It writes that vector to the addressed VRF banks and, when requested, forwards a copy to the host output port. It also raises per-instruction completion and interrupt pulses.

## Interface
- NVRF, 2: VRFs per bank group; vrf_id mask is 2*NVRF bits.
- VRFAW, 9: VRF address width.
- DW, 512: data vector width (EW*DOTW).
- UIW_LD, 2*NVRF+2*VRFAW+4: micro-instruction width.
- CNTW, 32: completed-vector counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- o_ld_uinst_rd_en  out  1  pop micro-instruction.
- i_ld_uinst_rd_rdy  in  1  micro-instruction available.
- i_ld_uinst_rd_dout  in  UIW_LD  micro-instruction (show-ahead).
- o_host_rd_en / i_host_rd_rdy / i_host_rd_dout  out/in/in  1/1/DW  host input vector FIFO.
- o_mfu_rd_en / i_mfu_rd_rdy / i_mfu_rd_dout  out/in/in  1/1/DW  MFU result vector FIFO.
- o_vrf_wr_en  out  2*NVRF  per-VRF write strobe.
- o_vrf0_wr_addr, o_vrf1_wr_addr  out  VRFAW  address for group 0 (bits NVRF-1:0) and group 1.
- o_vrf_wr_data  out  DW  write data.
- o_host_wr_en  out  1  host output valid.
- i_host_wr_rdy  in  1  host output accepts.
- o_host_wr_data  out  DW  host output data.
- o_inst_done  out  1  one-cycle pulse on the last vector of a macro instruction.
- o_interrupt  out  1  one-cycle pulse on a last vector with the interrupt bit set.
- o_vec_count  out  CNTW  vectors completed since reset (wraps).
- o_busy  out  1  any register stage holds valid content.

## Operation
- Micro-instruction fields, LSB first: vrf_id[2*NVRF], vrf0_addr[VRFAW], vrf1_addr[VRFAW], src_sel (0 host, 1 MFU), last, interrupt, report_to_host.
- Fire condition F = i_ld_uinst_rd_rdy & src_rdy & (!report_to_host | !hout_valid | i_host_wr_rdy). src_rdy is i_mfu_rd_rdy if src_sel else i_host_rd_rdy.
- On F, in the same cycle: assert o_ld_uinst_rd_en and the selected source rd_en. The unselected source is never popped.
- Write stage register, loaded on F:
  - o_vrf_wr_en = vrf_id; addresses and data are registered.
  - o_vrf_wr_en = 0 on cycles without F.
  - Addresses and data hold their last values.
- Host output holding register (hout):
  - Loaded on F when report_to_host = 1, and held until i_host_wr_rdy.
  - o_host_wr_en = hout_valid.
  - Load and drain in the same cycle is allowed: new data replaces old, valid stays 1.
- vrf_id = 0 with report_to_host = 0 still consumes the vector (discard). o_vec_count increments.
- o_inst_done = registered (F & last). o_interrupt = registered (F & last & interrupt).
- o_vec_count += 1 per F, modulo 2^CNTW.
- State machine:
  - IDLE: no valid stage.
  - ACTIVE: write stage valid, or F this cycle.
  - STALL: hout valid and !i_host_wr_rdy.
  - o_busy = (state != IDLE).
  - STALL blocks F only for uinsts with report_to_host = 1. Non-reporting uinsts continue.

## Timing
- Latency: F in cycle n → VRF write, done and interrupt pulses in cycle n+1. hout is valid from cycle n+1.
- Throughput: one vector per cycle with no backpressure.
- Rd_en outputs are combinational from the rdy inputs and dout, with no registered dependency beyond hout_valid.
- Reset: all outputs 0, o_vec_count 0, state IDLE, hout_valid 0.
- Reset asserted mid-operation drops the in-flight write and the hout content. No pulses are emitted for the dropped vector.
- Source rdy deasserting mid-instruction stalls with no bubbles inserted beyond the stall itself.

## Structure
- Shared package (npu_pkg): field offset/width localparams and ld_uinst_t packed struct for the uinst layout, and the SRC_HOST/SRC_MFU constants.
- One sub-module, ld_exec_hout: a one-entry DW-wide valid/ready holding register with simultaneous load/drain.

## Test plan
- Host source, 4 uinsts: vrf_id=0b0001, vrf0_addr 10..13, last on the 4th, interrupt=1 → VRF0 writes at 10..13 in cycles n+1..n+4. o_inst_done and o_interrupt pulse once, at the 4th write. o_vec_count=4.
- MFU source, vrf_id=0b1010, vrf0_addr=5, vrf1_addr=7 → o_vrf_wr_en=0b1010, both addresses driven. i_mfu_rd_dout appears on the data bus. Host FIFO is not popped.
- report_to_host=1 ×3, i_host_wr_rdy=0 for 5 cycles → 1st vector is held. Further reporting uinsts are not popped; an interleaved non-reporting uinst completes. After rdy rises, the remaining two drain one per cycle.
- i_host_rd_rdy toggled 1/0 every cycle over 6 uinsts → 6 writes over 12 cycles, no duplicates or drops, addresses in order.
- vrf_id=0, report=0 → source popped, no VRF write, o_vec_count +1.
- rst asserted the cycle after F → no write and no pulse after reset. All outputs 0; o_busy=0.
